// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Flow-controlled pipeline stage register. It carries a payload and a bundle
// of control strobes between two pipeline stages using a valid/ready
// handshake. Control strobes are qualified by occupancy: an empty entry
// always holds all-zero strobes, so a bubble can never trigger a
// register write or memory write downstream. The payload is not cleared when
// an entry empties. It keeps its last value.
//
// With SKID=0 there is a single main entry. in_ready passes combinationally
// through from out_ready.
// With SKID=1 a second (skid) entry absorbs the one beat that arrives in the
// cycle when back-pressure first appears. in_ready is then taken directly
// from a flop and has no path from out_ready.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control-strobe width
//   SKID    0 = single entry, 1 = main + skid entry
//   CNT_W   stall-cycle counter width
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous active-high reset, clears all state
//   flush         synchronous kill of held and incoming beats
//   in_valid      upstream beat present
//   in_ready      stage accepts a beat this cycle
//   in_ctrl       upstream control strobes
//   in_data       upstream payload
//   out_valid     main entry holds a beat
//   out_ready     downstream consumes the beat this cycle
//   out_ctrl      registered strobes, zero whenever out_valid is low
//   out_data      registered payload
//   occupancy     number of beats held (0..2)
//   stall_cycles  saturating count of cycles with out_valid & ~out_ready
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CntOne;
  endfunction

  // Main entry (drives the outputs) and skid occupancy flag.
  logic              mainVld_p0;
  logic [CTRL_W-1:0] mainCtrl_p0;
  logic [DATA_W-1:0] mainData_p0;
  logic              skidVld_p0;
  logic [CNT_W-1:0]  stallCnt_p0;

  logic inFire;
  logic outFire;

  assign inFire  = in_valid & in_ready;
  assign outFire = mainVld_p0 & out_ready;

  generate
    if (SKID != 0) begin : gSkid
      logic [CTRL_W-1:0] skidCtrl_p0;
      logic [DATA_W-1:0] skidData_p0;

      // The skid flag is a flop, so upstream never sees out_ready
      // combinationally.
      assign in_ready = ~skidVld_p0;

      // ---- stage boundary: upstream -> main/skid entries ----
      always_ff @(posedge clock) begin
        if (reset) begin
          mainVld_p0  <= 1'b0;
          mainCtrl_p0 <= '0;
          mainData_p0 <= '0;
          skidVld_p0  <= 1'b0;
          skidCtrl_p0 <= '0;
          skidData_p0 <= '0;
        end else if (flush) begin
          // Any beat accepted this cycle is dropped together with the held ones.
          mainVld_p0  <= 1'b0;
          mainCtrl_p0 <= '0;
          skidVld_p0  <= 1'b0;
          skidCtrl_p0 <= '0;
        end else if (~mainVld_p0 | outFire) begin
          // Main is free next cycle. The older skid beat has priority over
          // new input. in_ready is low whenever skid is full, so the two
          // never compete.
          if (skidVld_p0) begin
            mainVld_p0  <= 1'b1;
            mainCtrl_p0 <= skidCtrl_p0;
            mainData_p0 <= skidData_p0;
            skidVld_p0  <= 1'b0;
            skidCtrl_p0 <= '0;
          end else if (inFire) begin
            mainVld_p0  <= 1'b1;
            mainCtrl_p0 <= in_ctrl;
            mainData_p0 <= in_data;
          end else begin
            mainVld_p0  <= 1'b0;
            mainCtrl_p0 <= '0;
          end
        end else if (inFire) begin
          // Main is stuck this cycle, so the incoming beat parks in skid.
          skidVld_p0  <= 1'b1;
          skidCtrl_p0 <= in_ctrl;
          skidData_p0 <= in_data;
        end
      end
    end else begin : gNoSkid
      assign skidVld_p0 = 1'b0;

      // Accept whenever the held beat leaves in the same cycle, so streaming
      // has no bubble.
      assign in_ready = ~mainVld_p0 | out_ready;

      // ---- stage boundary: upstream -> main entry ----
      always_ff @(posedge clock) begin
        if (reset) begin
          mainVld_p0  <= 1'b0;
          mainCtrl_p0 <= '0;
          mainData_p0 <= '0;
        end else if (flush) begin
          mainVld_p0  <= 1'b0;
          mainCtrl_p0 <= '0;
        end else if (inFire) begin
          mainVld_p0  <= 1'b1;
          mainCtrl_p0 <= in_ctrl;
          mainData_p0 <= in_data;
        end else if (outFire) begin
          mainVld_p0  <= 1'b0;
          mainCtrl_p0 <= '0;
        end
      end
    end
  endgenerate

  // ---- stall statistics: sampled on the current output state ----
  // Flush does not clear the counter. A stalled flush cycle still counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCnt_p0 <= '0;
    end else if (mainVld_p0 & ~out_ready) begin
      stallCnt_p0 <= satInc(stallCnt_p0);
    end
  end

  assign out_valid    = mainVld_p0;
  assign out_ctrl     = mainCtrl_p0;
  assign out_data     = mainData_p0;
  assign occupancy    = {1'b0, mainVld_p0} + {1'b0, skidVld_p0};
  assign stall_cycles = stallCnt_p0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b1;
  logic        fl   = 1'b0;
  logic        iv   = 1'b0;
  logic        ordy = 1'b0;
  logic [3:0]  ic   = '0;
  logic [31:0] id   = '0;

  // DUT A: skid buffer, 16-bit counter. DUT B: single entry, 4-bit counter.
  logic        aInReady, aOutValid, bInReady, bOutValid;
  logic [3:0]  aOutCtrl, bOutCtrl;
  logic [31:0] aOutData, bOutData;
  logic [1:0]  aOcc, bOcc;
  logic [15:0] aStall;
  logic [3:0]  bStall;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(16)) dutA (
    .clock(clk), .reset(rst), .flush(fl),
    .in_valid(iv), .in_ready(aInReady), .in_ctrl(ic), .in_data(id),
    .out_valid(aOutValid), .out_ready(ordy), .out_ctrl(aOutCtrl), .out_data(aOutData),
    .occupancy(aOcc), .stall_cycles(aStall)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(0), .CNT_W(4)) dutB (
    .clock(clk), .reset(rst), .flush(fl),
    .in_valid(iv), .in_ready(bInReady), .in_ctrl(ic), .in_data(id),
    .out_valid(bOutValid), .out_ready(ordy), .out_ctrl(bOutCtrl), .out_data(bOutData),
    .occupancy(bOcc), .stall_cycles(bStall)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: an ordered list of up to two held beats per DUT.
  int          cnt   [2];
  logic [31:0] md    [2][2];
  logic [3:0]  mc    [2][2];
  logic [31:0] lastD [2];
  int          stall [2];
  bit          aInFire, aOutFire;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit mReady(input int m);
    if (m == 0) return cnt[0] < 2;
    return (cnt[1] == 0) || ordy;
  endfunction

  task automatic checkDut(input int m);
    logic        ov, ir;
    logic [3:0]  oc, ec;
    logic [31:0] od;
    logic [1:0]  oq;
    logic [15:0] sc;
    string       p;
    if (m == 0) begin
      ov = aOutValid; ir = aInReady; oc = aOutCtrl; od = aOutData; oq = aOcc; sc = aStall; p = "A";
    end else begin
      ov = bOutValid; ir = bInReady; oc = bOutCtrl; od = bOutData; oq = bOcc; sc = {12'b0, bStall}; p = "B";
    end
    ec = (cnt[m] > 0) ? mc[m][0] : 4'h0;
    checkEq({p, ".out_valid"}, 64'(ov), 64'(cnt[m] > 0));
    checkEq({p, ".out_ctrl"}, 64'(oc), 64'(ec));
    checkEq({p, ".out_data"}, 64'(od), 64'(lastD[m]));
    checkEq({p, ".occupancy"}, 64'(oq), 64'(cnt[m]));
    checkEq({p, ".stall_cycles"}, 64'(sc), 64'(stall[m]));
    checkEq({p, ".in_ready"}, 64'(ir), 64'(mReady(m)));
  endtask

  task automatic modelStep(input int m);
    bit of, inf;
    int smax;
    of   = (cnt[m] > 0) && ordy;
    inf  = iv && mReady(m);
    smax = (m == 0) ? 65535 : 15;
    if (rst) begin
      cnt[m] = 0; lastD[m] = '0; stall[m] = 0;
    end else begin
      if (cnt[m] > 0 && !ordy && stall[m] < smax) stall[m]++;
      if (fl) begin
        cnt[m] = 0;
      end else begin
        if (of) begin
          md[m][0] = md[m][1]; mc[m][0] = mc[m][1]; cnt[m]--;
        end
        if (inf) begin
          md[m][cnt[m]] = id; mc[m][cnt[m]] = ic; cnt[m]++;
        end
      end
      if (cnt[m] > 0) lastD[m] = md[m][0];
    end
  endtask

  // One clock cycle: drive on the falling edge, compare, then advance the model.
  task automatic step(input bit r, input bit f, input bit v, input logic [3:0] c,
                      input logic [31:0] d, input bit o);
    @(negedge clk);
    rst = r; fl = f; iv = v; ic = c; id = d; ordy = o;
    #1;
    checkDut(0);
    checkDut(1);
    aInFire  = v && mReady(0);
    aOutFire = (cnt[0] > 0) && o;
    modelStep(0);
    modelStep(1);
  endtask

  int seq, expOut;
  bit o;

  initial begin
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0; lastD[m] = '0; stall[m] = 0;
      md[m][0] = '0; md[m][1] = '0; mc[m][0] = '0; mc[m][1] = '0;
    end

    // Reset held two cycles with an active-looking input
    step(1, 0, 1, 4'hF, 32'hDEAD_BEEF, 0);
    step(1, 0, 1, 4'hF, 32'hDEAD_BEEF, 0);
    step(0, 0, 0, 4'h0, 32'h0, 1);
    checkEq("rst.a_in_ready", 64'(aInReady), 64'd1);
    checkEq("rst.b_in_ready", 64'(bInReady), 64'd1);
    checkEq("rst.a_out_data", 64'(aOutData), 64'd0);

    // Streaming 1..8 with out_ready high
    seq = 1;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, seq <= 8, 4'h5, 32'(seq), 1);
      if (k >= 1 && k <= 8) begin
        checkEq("stream.valid", 64'(aOutValid), 64'd1);
        checkEq("stream.data", 64'(aOutData), 64'(k));
        checkEq("stream.ctrl", 64'(aOutCtrl), 64'h5);
      end
      if (aInFire) seq++;
    end

    // Back-pressure: out_ready low for 3 cycles while beat 1 is on the output
    seq = 1; expOut = 1;
    for (int k = 0; k < 30; k++) begin
      o = !(k >= 1 && k <= 3);
      step(0, 0, seq <= 5, 4'h3, 32'(seq), o);
      if (k == 4) begin
        checkEq("bp.occupancy", 64'(aOcc), 64'd2);
        checkEq("bp.in_ready", 64'(aInReady), 64'd0);
        checkEq("bp.stall", 64'(aStall), 64'd3);
      end
      if (aOutFire) begin
        checkEq("bp.order", 64'(aOutData), 64'(expOut));
        expOut++;
      end
      if (aInFire) seq++;
    end
    checkEq("bp.delivered", 64'(expOut), 64'd6);

    // Flush with two beats held and a third one offered
    step(0, 0, 0, 4'h0, 32'h0, 1);
    step(0, 0, 0, 4'h0, 32'h0, 1);
    step(0, 0, 1, 4'h9, 32'hA, 0);
    step(0, 0, 1, 4'h9, 32'hB, 0);
    step(0, 1, 1, 4'h9, 32'hC, 0);
    checkEq("flush.occ_before", 64'(aOcc), 64'd2);
    step(0, 0, 0, 4'h0, 32'h0, 0);
    checkEq("flush.valid", 64'(aOutValid), 64'd0);
    checkEq("flush.ctrl", 64'(aOutCtrl), 64'd0);
    checkEq("flush.occupancy", 64'(aOcc), 64'd0);
    checkEq("flush.in_ready", 64'(aInReady), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 4'h0, 32'h0, 1);
      checkEq("flush.noC", 64'(aOutValid), 64'd0);
    end

    // Flush on the single-entry stage while beats move both ways
    step(0, 0, 1, 4'h7, 32'h55, 1);
    step(0, 1, 1, 4'h7, 32'h66, 1);
    step(0, 0, 0, 4'h0, 32'h0, 1);
    checkEq("flushB.valid", 64'(bOutValid), 64'd0);
    checkEq("flushB.occupancy", 64'(bOcc), 64'd0);

    // Single-entry concurrency: X held, Y accepted while X leaves
    step(0, 0, 1, 4'h2, 32'h111, 1);
    step(0, 0, 1, 4'h4, 32'h222, 1);
    checkEq("conc.in_ready", 64'(bInReady), 64'd1);
    checkEq("conc.data_x", 64'(bOutData), 64'h111);
    step(0, 0, 0, 4'h0, 32'h0, 1);
    checkEq("conc.valid", 64'(bOutValid), 64'd1);
    checkEq("conc.data_y", 64'(bOutData), 64'h222);
    checkEq("conc.ctrl_y", 64'(bOutCtrl), 64'h4);

    // Stall counter saturation on the 4-bit counter
    step(0, 0, 1, 4'h1, 32'h333, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 4'h0, 32'h0, 0);
    step(0, 0, 0, 4'h0, 32'h0, 0);
    checkEq("sat.stall", 64'(bStall), 64'd15);
    step(1, 0, 0, 4'h0, 32'h0, 0);
    step(0, 0, 0, 4'h0, 32'h0, 1);
    checkEq("sat.reset", 64'(bStall), 64'd0);
    checkEq("sat.reset_a", 64'(aStall), 64'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)),
           $urandom, $urandom_range(0, 99) < 60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: generalised, flow-controlled successor to the fixed EX/MEM register. It carries an arbitrary payload plus a bundle of control strobes (register-write, memory-write, etc.) between two pipeline stages. It adds a valid/ready handshake, stall back-pressure, synchronous flush, and bubble qualification of control strobes. An optional two-entry skid buffer breaks the combinational ready path. It drops between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage core.

## Interface
Parameters:
- DATA_W, 32, payload width (instruction, ALU result, store data, concatenated by the instantiator); ≥1
- CTRL_W, 4, control-strobe width; strobes are forced to 0 whenever the entry holding them is empty; ≥1
- SKID, 1, 0 = single register, combinational in_ready; 1 = main + skid entry, registered in_ready
- CNT_W, 16, width of stall-cycle counter

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage accepts beat this cycle
- in_ctrl  in  CTRL_W  upstream control strobes
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  main entry holds a beat
- out_ready  in  1  downstream consumes beat this cycle
- out_ctrl  out  CTRL_W  registered control strobes, 0 when out_valid=0
- out_data  out  DATA_W  registered payload
- occupancy  out  2  beats held (0..1 if SKID=0, 0..2 if SKID=1)
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State: main entry (valid, ctrl, data); skid entry (same) only when SKID=1.
- SKID=0:
  - in_ready = ~main_valid | out_ready (combinational through out_ready).
  - On in_fire, main loads the input.
  - On out_fire without in_fire, main empties.
- SKID=1:
  - in_ready = ~skid_valid; a registered value with no path from out_ready.
  - Empty main, or main firing out: in_fire loads main.
  - Main full and not firing: in_fire loads skid.
  - out_fire with skid_valid: skid moves to main, skid empties.
  - Order is strictly FIFO.
- Bubble qualification:
  - Whenever an entry is or becomes empty, its ctrl register is written 0.
  - data is not cleared (it holds its last value).
  - out_ctrl = 0 whenever out_valid = 0.
- Flush:
  - Empties both entries and zeroes their ctrl.
  - Any in_fire in the same cycle is discarded.
  - out_fire in the flush cycle still counts as consumed downstream.
- Priority: reset > flush > normal operation.
- stall_cycles:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.
- occupancy = main_valid + skid_valid.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0.
  - in_ready=1 (SKID=1) on the cycle after reset; with SKID=0 it is also 1, since main is empty.
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle) when main is empty.
  - If it landed in the skid entry, it appears 1 cycle after the main entry's out_fire.
- Throughput: 1 beat/cycle sustained with out_ready=1 for both SKID settings.
- SKID=1 stall: with out_ready dropped, one more beat is accepted (into skid), then in_ready=0 from the next cycle.
  - in_ready returns to 1 the cycle after the skid entry drains.
- Simultaneous in_fire and out_fire with SKID=0: main reloads and out_valid stays 1 (no bubble).
- Reset or flush mid-stall: both entries empty next cycle and in_ready=1; stall counting stops.
- Inputs are sampled only at the rising edge; no combinational in→out path exists except in_ready←out_ready when SKID=0.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_ctrl=4'hF → out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0; in_ready=1 after release.
- Streaming, SKID=1: beats data=1..8, ctrl=4'h5, out_ready=1 → outputs 1..8 on consecutive cycles, each 1 cycle after acceptance, no bubbles.
- Back-pressure, SKID=1: stream 1..5, drop out_ready for 3 cycles while beat 1 is on the output.
  - Expected: beat 2 captured in skid, in_ready=0, occupancy=2, stall_cycles=3.
  - After release, 1..5 are delivered in order with none lost or duplicated.
- Flush: occupancy=2 holding beats A,B with in_valid=1 carrying C, assert flush one cycle → next cycle out_valid=0, out_ctrl=0, occupancy=0; C never appears.
- SKID=0 concurrency: main holds X, out_ready=1, in_valid=1 with Y in the same cycle → in_ready=1 combinationally, Y on output next cycle, out_valid continuous.
- Saturation: CNT_W=4, stall for 20 cycles → stall_cycles stops at 15; reset returns it to 0.
